// File: rtl/pulse_gen.sv
// Programmable pulse-train generator: bursts of N pulses or a continuous train
// with latched period/high time and a start/busy/done handshake.
module pulse_gen #(
  parameter int PER_W = 24,
  parameter int PW_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [PER_W-1:0] period,
  input  logic [PW_W-1:0]  width,
  input  logic [7:0]       count,
  output logic             pulso,
  output logic             busy,
  output logic             done,
  output logic [7:0]       sent
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [PER_W-1:0] wid_q, wid_d;
  logic [PER_W-1:0] low_q, low_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [PER_W-1:0] phase_q, phase_d;
  logic [7:0]       sent_q, sent_d;
  logic             stop_pend_q, stop_pend_d;
  logic             pulso_q, pulso_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [PER_W-1:0] p_eff_s;
  logic [PER_W-1:0] width_ext_s;
  logic [PER_W-1:0] w_eff_s;
  logic             more_due_s;
  logic             stop_seen_s;

  // Effective period and clamped high time derived from the raw inputs.
  always_comb begin
    width_ext_s = PER_W'(width);
    if (period < PER_W'(32'd2)) begin
      p_eff_s = PER_W'(32'd2);
    end else begin
      p_eff_s = period;
    end
    if (width_ext_s == {PER_W{1'b0}}) begin
      w_eff_s = PER_W'(32'd1);
    end else if (width_ext_s >= p_eff_s) begin
      w_eff_s = p_eff_s - PER_W'(32'd1);
    end else begin
      w_eff_s = width_ext_s;
    end
  end

  // A count of zero means continuous; sent only wraps in that mode.
  assign more_due_s  = (cnt_q == 8'd0) || (sent_q < cnt_q);
  assign stop_seen_s = stop_pend_q | stop;

  // Next-state and output computation for the IDLE/HIGH/LOW sequencer.
  always_comb begin
    state_d     = state_q;
    wid_d       = wid_q;
    low_d       = low_q;
    cnt_d       = cnt_q;
    phase_d     = phase_q;
    sent_d      = sent_q;
    stop_pend_d = stop_pend_q;
    pulso_d     = pulso_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        pulso_d     = 1'b0;
        busy_d      = 1'b0;
        stop_pend_d = 1'b0;
        if (start) begin
          wid_d   = w_eff_s;
          low_d   = p_eff_s - w_eff_s;
          cnt_d   = count;
          phase_d = PER_W'(32'd1);
          sent_d  = 8'd1;
          pulso_d = 1'b1;
          busy_d  = 1'b1;
          state_d = HIGH;
        end else begin
          state_d = IDLE;
        end
      end
      HIGH: begin
        stop_pend_d = stop_seen_s;
        if (phase_q == wid_q) begin
          phase_d = PER_W'(32'd1);
          pulso_d = 1'b0;
          state_d = LOW;
        end else begin
          phase_d = phase_q + PER_W'(32'd1);
        end
      end
      LOW: begin
        if (phase_q == low_q) begin
          phase_d = PER_W'(32'd1);
          if (more_due_s && !stop_seen_s) begin
            sent_d      = sent_q + 8'd1;
            pulso_d     = 1'b1;
            stop_pend_d = 1'b0;
            state_d     = HIGH;
          end else begin
            busy_d      = 1'b0;
            done_d      = 1'b1;
            stop_pend_d = 1'b0;
            state_d     = IDLE;
          end
        end else begin
          phase_d     = phase_q + PER_W'(32'd1);
          stop_pend_d = stop_seen_s;
        end
      end
      default: begin
        pulso_d     = 1'b0;
        busy_d      = 1'b0;
        stop_pend_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wid_q       <= {PER_W{1'b0}};
      low_q       <= {PER_W{1'b0}};
      cnt_q       <= 8'd0;
      phase_q     <= {PER_W{1'b0}};
      sent_q      <= 8'd0;
      stop_pend_q <= 1'b0;
      pulso_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wid_q       <= wid_d;
      low_q       <= low_d;
      cnt_q       <= cnt_d;
      phase_q     <= phase_d;
      sent_q      <= sent_d;
      stop_pend_q <= stop_pend_d;
      pulso_q     <= pulso_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign pulso = pulso_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign sent  = sent_q;

endmodule

// File: tb/tb_pulse_gen.sv
// Directed self-checking bench for pulse_gen: bursts, clamping, continuous
// mode with stop, handshake corner cases and mid-pulse reset.
module tb_pulse_gen;

  logic        clk;
  logic        rst;
  logic        start;
  logic        stop;
  logic [23:0] period;
  logic [15:0] width;
  logic [7:0]  count;
  logic        pulso;
  logic        busy;
  logic        done;
  logic [7:0]  sent;

  int n_total;
  int n_pass;

  logic       pl [1:64];
  logic       dn [1:64];
  logic       bz [1:64];
  logic [7:0] st [1:64];

  pulse_gen #(.PER_W(24), .PW_W(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .stop   (stop),
    .period (period),
    .width  (width),
    .count  (count),
    .pulso  (pulso),
    .busy   (busy),
    .done   (done),
    .sent   (sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Expected pulso in cycle i (1 = first cycle after the start edge).
  function automatic logic exp_p(input int i, input int p, input int w, input int n);
    int k;
    k = i - 1;
    if (n != 0 && k >= n * p) return 1'b0;
    return ((k % p) < w);
  endfunction

  // Called at a negedge; returns at the negedge of cycle 1 of the train.
  task automatic start_train(input int p, input int w, input int n, input logic stp);
    period = 24'(p);
    width  = 16'(w);
    count  = 8'(n);
    start  = 1'b1;
    stop   = stp;
    @(negedge clk);
    start  = 1'b0;
    stop   = 1'b0;
  endtask

  // Record outputs for cycles 1..len; optionally fire a new start in cycle inj.
  task automatic capture(input int len, input int inj, input int ip, input int iw, input int in_n);
    for (int i = 1; i <= len; i++) begin
      pl[i] = pulso;
      dn[i] = done;
      bz[i] = busy;
      st[i] = sent;
      if (i == inj) begin
        period = 24'(ip);
        width  = 16'(iw);
        count  = 8'(in_n);
        start  = 1'b1;
      end else begin
        start  = 1'b0;
      end
      if (i < len) @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic verify(input string name, input int p, input int w, input int n, input int len);
    int last;
    last = n * p + 1;
    for (int i = 1; i <= len; i++) begin
      chk($sformatf("%s_pulso_c%0d", name, i), pl[i], exp_p(i, p, w, n));
      chk($sformatf("%s_done_c%0d", name, i), dn[i], (i == last));
      chk($sformatf("%s_busy_c%0d", name, i), bz[i], (i < last));
    end
    chk({name, "_sent_first"}, st[1], 32'd1);
    chk({name, "_sent_end"}, st[len], 32'(n));
  endtask

  initial begin
    int edges;
    logic prev;
    n_total = 0;
    n_pass  = 0;
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    period = 24'd0; width = 16'd0; count = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_pulso", pulso, 32'd0);
    chk("rst_busy", busy, 32'd0);
    chk("rst_done", done, 32'd0);
    chk("rst_sent", sent, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Stop in IDLE must not leave a pending flag behind.
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("idle_stop_busy", busy, 32'd0);

    // Burst P=10 W=3 N=4: edges at 1/11/21/31, done at 41.
    start_train(10, 3, 4, 1'b0);
    capture(45, 0, 0, 0, 0);
    verify("burst", 10, 3, 4, 45);
    chk("burst_done41", dn[41], 32'd1);
    @(negedge clk);

    // Clamp: width 0 -> 1-cycle pulses every 5.
    start_train(5, 0, 3, 1'b0);
    capture(17, 0, 0, 0, 0);
    verify("w0", 5, 1, 3, 17);
    @(negedge clk);

    // Clamp: width 12 period 10 -> 9 high, 1 low.
    start_train(10, 12, 2, 1'b0);
    capture(22, 0, 0, 0, 0);
    verify("wbig", 10, 9, 2, 22);
    @(negedge clk);

    // Clamp: period 1 -> P=2, W=1.
    start_train(1, 5, 3, 1'b0);
    capture(8, 0, 0, 0, 0);
    verify("p1", 2, 1, 3, 8);
    @(negedge clk);

    // Start while busy with new parameters is ignored.
    start_train(6, 2, 3, 1'b0);
    capture(19, 3, 10, 5, 7);
    verify("busystart", 6, 2, 3, 19);
    @(negedge clk);

    // Start+stop together in IDLE starts a train; restart in the done cycle.
    start_train(4, 1, 2, 1'b1);
    capture(9, 0, 0, 0, 0);
    verify("startstop", 4, 1, 2, 9);
    start_train(3, 1, 2, 1'b0);
    capture(7, 0, 0, 0, 0);
    verify("restart", 3, 1, 2, 7);
    @(negedge clk);

    // Continuous P=4 W=2: 300 pulses, sent wraps to 44, then stop mid-high.
    start_train(4, 2, 0, 1'b0);
    edges = 0;
    prev  = 1'b0;
    for (int c = 1; c <= 1197; c++) begin
      if (pulso && !prev) edges++;
      prev = pulso;
      if (c < 1197) @(negedge clk);
    end
    chk("cont_edges", 32'(edges), 32'd300);
    chk("cont_sent_wrap", sent, 32'd44);
    chk("cont_high", pulso, 32'd1);
    stop = 1'b1;
    for (int c = 1198; c <= 1206; c++) begin
      @(negedge clk);
      stop = 1'b0;
      chk($sformatf("stop_pulso_c%0d", c), pulso, (c == 1198));
      chk($sformatf("stop_done_c%0d", c), done, (c == 1201));
      chk($sformatf("stop_busy_c%0d", c), busy, (c <= 1200));
    end
    chk("stop_sent_hold", sent, 32'd44);
    @(negedge clk);

    // Reset mid-high of the second pulse, then a clean 5-pulse burst.
    start_train(8, 4, 5, 1'b0);
    repeat (9) @(negedge clk);
    chk("prerst_high", pulso, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_pulso", pulso, 32'd0);
    chk("midrst_busy", busy, 32'd0);
    chk("midrst_done", done, 32'd0);
    chk("midrst_sent", sent, 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("postrst_idle_pulso", pulso, 32'd0);
    chk("postrst_idle_busy", busy, 32'd0);
    start_train(8, 4, 5, 1'b0);
    capture(41, 0, 0, 0, 0);
    verify("afterrst", 8, 4, 5, 41);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pulse_gen.md
# pulse_gen

Programmable pulse-train generator: the transmit side of the pulse-counting path. Emits a burst of N rectangular pulses, or a continuous train, on `pulso` with a programmable period and high time. Used to stimulate the pulse counter from on-chip logic and to drive an external test pulse in place of the heart-rate sensor. Start/busy/done handshake to the controlling FSM.

## Interface
- `PER_W`, 24: width of the period value, in clock cycles
- `PW_W`, 16: width of the high-time value, in clock cycles

- `clk`  in  1  system clock
- `rst`  in  1  reset; synchronous, active-high
- `start`  in  1  1-cycle request; sampled only in IDLE
- `stop`  in  1  request to end the train after the current pulse period
- `period`  in  PER_W  cycles between rising edges; latched at accepted start
- `width`  in  PW_W  high cycles per pulse; latched at accepted start
- `count`  in  8  pulses to send; 0 = continuous until `stop`; latched at start
- `pulso`  out  1  registered pulse output
- `busy`  out  1  high while a train is in progress
- `done`  out  1  1-cycle strobe when a train ends
- `sent`  out  8  rising edges emitted in the current/last train

## Operation
- FSM states: IDLE, HIGH, LOW.
  - IDLE: `pulso`=0, `busy`=0.
  - IDLE→HIGH on `start`.
  - HIGH→LOW after W cycles.
  - LOW→HIGH after P−W cycles if more pulses are due and no stop is pending.
  - Otherwise LOW→IDLE with `done`.
- Latched effective values at accepted start:
  - P = max(`period`, 2).
  - W = `width` clamped to 1..P−1; `width`=0 gives W=1; `width`≥P gives W=P−1.
  - N = `count`.
- Width rules:
  - Phase counter is PER_W bits.
  - W is zero-extended to PER_W before comparison.
  - Counters never wrap inside a phase.
- `sent`:
  - Cleared to 0 on accepted start.
  - +1 on every HIGH entry.
  - 8-bit; wraps 255→0 in continuous mode.
  - Holds its value in IDLE.
- Burst mode (N>0): LOW→IDLE at the end of the low phase of pulse N.
- Continuous mode (N=0): runs until `stop`.
- `stop` while HIGH or LOW sets a pending flag.
  - The current pulse completes its full high and low phases, then the FSM goes to IDLE.
  - No truncated pulse is emitted.
  - Applies in both modes; in burst mode it can only shorten the train.
- `stop` in IDLE: ignored; the flag is never set.
- `start` while busy: ignored.
- `start` and `stop` in the same IDLE cycle: start accepted, stop ignored.
- Changes to `period`/`width`/`count` while busy take no effect until the next start.
- `rst`:
  - At any time, next edge: `pulso`=0, `busy`=0, `done`=0, `sent`=0, FSM=IDLE, stop flag cleared.
  - Reset mid-pulse may shorten the current high time.

## Timing
- All outputs registered. Reset values: `pulso`=0, `busy`=0, `done`=0, `sent`=0.
- `start` sampled high at edge T (cycle T):
  - `pulso`=1 and `busy`=1 from T+1.
  - `sent`=1 at T+1.
- Rising edges of `pulso` at T+1+k·P.
- `pulso` high for exactly W cycles per pulse, low for P−W cycles.
- Burst end: at T+1+N·P, `busy`=0 and `done`=1 for exactly one cycle; `pulso` stays 0.
- Stop sampled during pulse k (0-based): `done` at T+1+(k+1)·P.
- A new start is accepted in the `done` cycle (FSM already IDLE). Back-to-back trains are therefore separated by no extra gap beyond that cycle.
- `pulso` is glitch-free: it comes directly from a flop.
- The counter's 2-flop synchronizer adds 2 cycles at the receiver; no constraint on pulse_gen.

## Test plan
- Burst: P=10, W=3, N=4, start at T.
  - Rising edges at T+1/11/21/31, each 3 cycles high.
  - `done` at T+41, `sent`=4.
  - Looped into the pulse counter with enable=1, its count reads 4.
- Clamping:
  - `width`=0, P=5 → 1-cycle pulses every 5 cycles.
  - `width`=12, `period`=10 → 9 high, 1 low.
  - `period`=1 → P=2, W=1.
- Continuous: N=0, P=4, W=2.
  - Runs 300 pulses; `sent` wraps to 44.
  - `stop` asserted during the high phase of a pulse → that pulse completes full 2 high + 2 low, then `done`; no further edges.
- Handshake:
  - `start` while busy with new params → ignored; edges keep the old P.
  - `start`+`stop` in IDLE → train starts.
  - Restart in the `done` cycle → new train begins the next cycle.
- Reset:
  - `rst` mid-HIGH of pulse 2 of N=5 → next cycle all outputs 0, IDLE.
  - A following start runs a clean 5-pulse burst with `sent`=5.
